rotl_seq: RTL and testbench
===========================

Name: rotl_seq

Overview:
Sequential 32-bit left-rotate unit: the left-rotation counterpart of the existing combinational right-rotate. It accepts a word and a rotate amount over a valid/ready handshake and rotates left by up to STEP bits per clock. It presents the result on a valid/ready output port. Used by SHA-256 datapath control where a variable left rotation is needed and area matters more than latency.

Parameters:
WIDTH, 32, data word width in bits.
AMT_W, 5, rotate-amount width; must equal log2(WIDTH).
STEP, 1, maximum bits rotated per clock; legal range 1..WIDTH-1.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  input word and amount are valid.
in_ready  output  1  block can accept input; high only in IDLE.
in_data  input  WIDTH  word to rotate.
in_amt  input  AMT_W  left-rotate amount, 0..WIDTH-1.
out_valid  output  1  result valid; held until accepted.
out_ready  input  1  downstream accepts result.
out_data  output  WIDTH  rotated word; stable while out_valid is high.
busy  output  1  high in ROTATE or DONE.

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE; in_ready=1; out_valid=0; busy=0; out_data=0; internal data and remaining-count registers=0.
- FSM states: IDLE, ROTATE, DONE. All registers are updated on the rising edge of clk.
- IDLE: in_ready=1. When in_valid=1, latch in_data into the data register and in_amt into the remaining count rem. If in_amt=0, go to DONE; otherwise go to ROTATE. When in_valid=0, stay in IDLE.
- ROTATE: each clock, set k = min(rem, STEP), rotate data left by k (bit i moves to bit (i+k) mod WIDTH), and set rem = rem - k. When the new rem is 0, go to DONE. in_ready=0.
- DONE: out_valid=1 and out_data=data register. When out_ready=1, go to IDLE and drop out_valid on the next cycle. When out_ready=0, hold out_data and out_valid unchanged indefinitely.
- Latency: the acceptance cycle is cycle 0. out_valid first goes high in cycle 1+ceil(in_amt/STEP). For in_amt=0 this is cycle 1.
- Throughput: one word per (2+ceil(in_amt/STEP)) cycles when out_ready is held high. Input is not accepted in the same cycle as output handoff.
- in_data and in_amt are ignored whenever in_ready=0. Changing them mid-operation has no effect.
- out_data outside DONE: holds the last register value. Consumers must qualify it with out_valid.
- Rotation arithmetic is purely modular. There is no carry or fill; the popcount of data is invariant across every cycle.
- Reset asserted mid-ROTATE or mid-DONE aborts the operation immediately: all outputs return to their reset values and the pending result is discarded.
- busy = (state != IDLE).

Decomposition:
- Shared package holds the state enumeration (IDLE=2'd0, ROTATE=2'd1, DONE=2'd2) and WIDTH/AMT_W defaults, for reuse by the SHA-256 datapath.
- One sub-module, rotl_step: combinational rotate-left of WIDTH bits by k in 0..STEP. It mirrors the existing right-rotate unit and is instantiated once.

Test Plan:
- STEP=1, in_data=0x80000001, in_amt=1 -> out_valid in cycle 2, out_data=0x00000003.
- STEP=1, in_data=0x12345678, in_amt=4 -> out_valid in cycle 5, out_data=0x23456781; in_ready=0 during cycles 1-5.
- in_amt=0, in_data=0xDEADBEEF -> out_valid in cycle 1, out_data=0xDEADBEEF. Then STEP=1, in_data=0x00000001, in_amt=31 -> out_valid in cycle 32, out_data=0x80000000.
- STEP=4, in_data=0x12345678, in_amt=6 (k=4 then k=2) -> out_valid in cycle 3, out_data=0x8D159E04.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid=1 and out_data stable throughout, in_ready=0. Raise out_ready -> IDLE next cycle, in_ready=1.
- Pull rst_n low mid-ROTATE (in_amt=20, cycle 7) -> out_valid=0, busy=0, in_ready=1 and out_data=0 immediately, without waiting for a clock edge. After release, a fresh transaction completes correctly.

Source files
------------

// File: rtl/rotl_seq_pkg.sv
// Shared definitions for the sequential rotate-left unit and the SHA-256 datapath.
package rotl_seq_pkg;
    localparam int WIDTH_DEF = 32;
    localparam int AMT_W_DEF = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        DONE   = 2'd2
    } state_t;
endpackage

// File: rtl/rotl_step.sv
// Combinational rotate-left of WIDTH bits by k; the left-hand twin of the right-rotate unit.
module rotl_step
    import rotl_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int AMT_W = AMT_W_DEF
) (
    input  logic [WIDTH-1:0] data,
    input  logic [AMT_W-1:0] k,
    output logic [WIDTH-1:0] result
);
    logic [2*WIDTH-1:0] dbl;

    // The upper half of the shifted doubled word is the modular rotation.
    assign dbl    = {data, data} << k;
    assign result = dbl[2*WIDTH-1:WIDTH];
endmodule

// File: rtl/rotl_seq.sv
// Sequential rotate-left: accepts one word, rotates up to STEP bits per clock, presents result.
module rotl_seq
    import rotl_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int AMT_W = AMT_W_DEF,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic [1:0]       state_dbg
);
    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // out_valid and out_data hold until out_ready is seen, and ready never depends on valid.
    localparam logic [AMT_W-1:0] STEP_K = AMT_W'(STEP);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] data_q;
    logic [AMT_W-1:0] rem;
    logic [AMT_W-1:0] k;
    logic [AMT_W-1:0] rem_nx;
    logic [WIDTH-1:0] rotated;

    assign k      = (rem < STEP_K) ? rem : STEP_K;
    assign rem_nx = rem - k;

    rotl_step #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) u_step (
        .data   (data_q),
        .k      (k),
        .result (rotated)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            rem    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_q <= in_data;
                        rem    <= in_amt;
                    end
                end
                ROTATE: begin
                    data_q <= rotated;
                    rem    <= rem_nx;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nx = (in_amt == '0) ? DONE : ROTATE;
                end
            end
            ROTATE: begin
                if (rem_nx == '0) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        state_dbg = state;
        out_data  = data_q;
    end
endmodule

// File: tb/tb_rotl_seq.sv
// Directed bench for rotl_seq with STEP=1 and STEP=4 instances and a queue-based scoreboard.
module tb_rotl_seq;
    logic        clk;
    logic        rst_n;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [31:0] in_data   [2];
    logic [4:0]  in_amt    [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [31:0] out_data  [2];
    logic        busy      [2];
    logic [1:0]  state_dbg [2];

    logic [39:0] exp_q0[$];
    logic [39:0] exp_q1[$];
    int          acc_q0[$];
    int          acc_q1[$];
    int          checks = 0;
    int          failures = 0;
    int          ecnt = 0;
    logic        prev_valid [2];

    rotl_seq #(.WIDTH(32), .AMT_W(5), .STEP(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_amt(in_amt[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0]),
        .state_dbg(state_dbg[0])
    );

    rotl_seq #(.WIDTH(32), .AMT_W(5), .STEP(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_amt(in_amt[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1]),
        .state_dbg(state_dbg[1])
    );

    // Clock and cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) ecnt <= ecnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Monitor: first cycle of each out_valid pulse is compared against the scoreboard
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst_n && out_valid[d] && !prev_valid[d]) begin
                logic [39:0] e;
                int          acc;
                int          qn;
                qn = (d == 0) ? exp_q0.size() : exp_q1.size();
                if (qn == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out dut%0d: actual=0x%08h required=no output", d, out_data[d]);
                end else begin
                    if (d == 0) begin
                        e = exp_q0.pop_front();
                        acc = acc_q0.pop_front();
                    end else begin
                        e = exp_q1.pop_front();
                        acc = acc_q1.pop_front();
                    end
                    check($sformatf("out_data dut%0d", d), out_data[d], e[31:0]);
                    check($sformatf("latency dut%0d", d), 32'(ecnt - acc), {24'd0, e[39:32]});
                    check($sformatf("in_ready_in_done dut%0d", d), {31'd0, in_ready[d]}, 32'd0);
                end
            end
            prev_valid[d] = out_valid[d];
        end
    end

    // Driver: present one word and push its expected result and latency
    task automatic issue(input int d, input logic [31:0] data, input logic [4:0] amt,
                         input logic [31:0] exp, input logic [7:0] lat);
        int n;
        @(negedge clk);
        in_data[d]  = data;
        in_amt[d]   = amt;
        in_valid[d] = 1'b1;
        n = 0;
        while (!in_ready[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready[d]) begin
            checks++;
            failures++;
            $display("FAIL in_ready_timeout dut%0d: actual=0 required=1", d);
        end
        if (d == 0) begin
            exp_q0.push_back({lat, exp});
            acc_q0.push_back(ecnt);
        end else begin
            exp_q1.push_back({lat, exp});
            acc_q1.push_back(ecnt);
        end
        @(negedge clk);
        in_valid[d] = 1'b0;
        in_data[d]  = $urandom();
        in_amt[d]   = 5'($urandom_range(0, 31));
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while (((d == 0) ? exp_q0.size() : exp_q1.size()) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        while (!in_ready[d] && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 300) begin
            failures++;
            $display("FAIL drain_timeout dut%0d: actual=pending required=idle", d);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            in_valid[d]   = 1'b0;
            in_data[d]    = '0;
            in_amt[d]     = '0;
            out_ready[d]  = 1'b1;
            prev_valid[d] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst in_ready dut%0d", d), {31'd0, in_ready[d]}, 32'd1);
            check($sformatf("rst out_valid dut%0d", d), {31'd0, out_valid[d]}, 32'd0);
            check($sformatf("rst busy dut%0d", d), {31'd0, busy[d]}, 32'd0);
            check($sformatf("rst out_data dut%0d", d), out_data[d], 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        issue(0, 32'h8000_0001, 5'd1, 32'h0000_0003, 8'd2);
        drain(0);
        issue(0, 32'h1234_5678, 5'd4, 32'h2345_6781, 8'd5);
        drain(0);
        issue(0, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 8'd1);
        drain(0);
        issue(0, 32'h0000_0001, 5'd31, 32'h8000_0000, 8'd32);
        drain(0);
        issue(1, 32'h1234_5678, 5'd6, 32'h8D15_9E04, 8'd3);
        drain(1);
        issue(1, 32'h8000_0001, 5'd31, 32'hC000_0000, 8'd9);
        drain(1);

        // Backpressure: result must hold while out_ready stays low
        out_ready[0] = 1'b0;
        issue(0, 32'hA5A5_0F0F, 5'd3, 32'h2D28_787D, 8'd4);
        for (int n = 0; n < 50 && !out_valid[0]; n++) @(negedge clk);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check("hold out_valid", {31'd0, out_valid[0]}, 32'd1);
            check("hold out_data", out_data[0], 32'h2D28_787D);
            check("hold in_ready", {31'd0, in_ready[0]}, 32'd0);
        end
        out_ready[0] = 1'b1;
        @(negedge clk);
        check("release in_ready", {31'd0, in_ready[0]}, 32'd1);
        check("release out_valid", {31'd0, out_valid[0]}, 32'd0);

        // Asynchronous reset mid-rotation discards the pending result
        issue(0, 32'h0000_FFFF, 5'd20, 32'hFFF0_000F, 8'd21);
        repeat (6) @(negedge clk);
        check("pre_reset state", {30'd0, state_dbg[0]}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async out_valid", {31'd0, out_valid[0]}, 32'd0);
        check("async busy", {31'd0, busy[0]}, 32'd0);
        check("async in_ready", {31'd0, in_ready[0]}, 32'd1);
        check("async out_data", out_data[0], 32'd0);
        check("async state", {30'd0, state_dbg[0]}, 32'd0);
        exp_q0.delete();
        acc_q0.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(0, 32'hF000_0000, 5'd5, 32'h0000_001E, 8'd6);
        drain(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
